regfile_multiport: RTL and testbench

//  Parametrised general-purpose register file for the datapath: NREAD combinational read ports,
//  one synchronous write port, optional write-to-read bypass, hardwired-zero register 0, and a
//  per-register busy scoreboard. A post-reset clear sequencer zeroes all entries, one per cycle.

---
 rtl/regfile_multiport.sv | 135 +++++++++++++
 tb/tb_regfile_multiport.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-port general-purpose register file with combinational reads, one synchronous
// write port, optional write-to-read bypass, hardwired-zero register 0, a per-register
// busy scoreboard, and a post-reset clear sequencer that zeroes one entry per cycle.
module regfile_multiport #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NREAD    = 2,
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    output logic                             ready,
    input  logic                             regwrite,
    input  logic [$clog2(DEPTH)-1:0]         writeRegister,
    input  logic [WIDTH-1:0]                 writeData,
    input  logic [NREAD*$clog2(DEPTH)-1:0]   readRegisters,
    output logic [NREAD*WIDTH-1:0]           readData,
    input  logic                             reserve,
    input  logic [$clog2(DEPTH)-1:0]         reserveRegister,
    output logic [NREAD-1:0]                 readBusy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              run;
    logic              wr_ok;
    logic              rsv_ok;
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [AW-1:0]     rd_addr [NREAD];

    // Operations are only honoured once the clear has finished and reset is low.
    assign run   = (state_q == StRun) && !reset;
    assign ready = run;

    // Writes/reserves aimed at the hardwired-zero register are dropped here, so neither the
    // array nor the scoreboard ever sees them.
    assign wr_ok  = run && regwrite && !(ZERO_REG && (writeRegister == '0));
    assign rsv_ok = run && reserve  && !(ZERO_REG && (reserveRegister == '0));

    // Split the flat read-address bus into one address per port.
    for (genvar g = 0; g < NREAD; g++) begin : g_rd_addr
        assign rd_addr[g] = readRegisters[g*AW +: AW];
    end

    // Clear sequencer: walk the index once through every entry, then enter run.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == StClear) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == LastIdx) begin
                state_d = StRun;
            end
        end
    end

    // Array write port: the clear sequencer owns it until run, then the writeback port.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = writeRegister;
        mem_wdata = writeData;
        if (!reset) begin
            if (state_q == StClear) begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx_q;
                mem_wdata = '0;
            end else begin
                mem_we    = wr_ok;
            end
        end
    end

    // Scoreboard update: a write releases, a reserve sets; reserve is applied last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[writeRegister] = 1'b0;
        end
        if (rsv_ok) begin
            busy_d[reserveRegister] = 1'b1;
        end
    end

    // Control state and scoreboard registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            busy_q    <= busy_d;
        end
    end

    // Register array storage; contents are undefined until the clear sequence completes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Read ports: zero while not running, zero for r0, bypassed write data, else stored entry.
    always_comb begin
        readData = '0;
        readBusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (run) begin
                if (ZERO_REG && (rd_addr[i] == '0)) begin
                    readData[i*WIDTH +: WIDTH] = '0;
                    readBusy[i]                = 1'b0;
                end else if (BYPASS && wr_ok && (rd_addr[i] == writeRegister)) begin
                    readData[i*WIDTH +: WIDTH] = writeData;
                    readBusy[i]                = 1'b0;
                end else begin
                    readData[i*WIDTH +: WIDTH] = mem_q[rd_addr[i]];
                    readBusy[i]                = busy_q[rd_addr[i]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: one bypassing and one non-bypassing instance share
// the same stimulus; expected values are hand-derived constants.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        reset;
    logic        regwrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [9:0]  readRegisters;
    logic        reserve;
    logic [4:0]  reserveRegister;

    logic        ready_a, ready_b;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  rbusy_a, rbusy_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_multiport #(
        .WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .ready(ready_a), .regwrite(regwrite),
        .writeRegister(writeRegister), .writeData(writeData),
        .readRegisters(readRegisters), .readData(rdata_a),
        .reserve(reserve), .reserveRegister(reserveRegister), .readBusy(rbusy_a)
    );

    regfile_multiport #(
        .WIDTH(32), .DEPTH(32), .NREAD(2), .BYPASS(1'b0), .ZERO_REG(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .ready(ready_b), .regwrite(regwrite),
        .writeRegister(writeRegister), .writeData(writeData),
        .readRegisters(readRegisters), .readData(rdata_b),
        .reserve(reserve), .reserveRegister(reserveRegister), .readBusy(rbusy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        readRegisters = {a1, a0};
        #1;
    endtask

    // Count the clear: ready low for 32 cycles, high on the 32nd edge after reset drops.
    task automatic clear_wait(input string tag);
        int low_bad = 0;
        for (int c = 0; c < 32; c++) begin
            if (ready_a !== 1'b0 || ready_b !== 1'b0) low_bad++;
            step();
        end
        chk({tag, "_ready_low_cycles_bad"}, 32'(low_bad), 32'd0);
        chk({tag, "_ready_a"}, {31'd0, ready_a}, 32'd1);
        chk({tag, "_ready_b"}, {31'd0, ready_b}, 32'd1);
    endtask

    initial begin
        int zero_bad;
        reset = 1'b1; regwrite = 1'b0; writeRegister = '0; writeData = '0;
        readRegisters = '0; reserve = 1'b0; reserveRegister = '0;
        step(); step();
        chk("reset_ready", {31'd0, ready_a}, 32'd0);
        chk("reset_busy", {30'd0, rbusy_a}, 32'd0);

        // 1. Clear sequence and all-zero contents.
        reset = 1'b0;
        clear_wait("clr1");
        zero_bad = 0;
        for (int r = 0; r < 32; r++) begin
            rd(5'(r), 5'(31 - r));
            if (rdata_a !== 64'd0 || rdata_b !== 64'd0 || rbusy_a !== 2'b00) zero_bad++;
        end
        chk("clr1_all_zero_bad", 32'(zero_bad), 32'd0);

        // 2. Write r5, read on both ports together.
        regwrite = 1'b1; writeRegister = 5'd5; writeData = 32'hDEADBEEF;
        step();
        regwrite = 1'b0;
        rd(5'd5, 5'd5);
        chk("wr_r5_p0", rdata_a[31:0], 32'hDEADBEEF);
        chk("wr_r5_p1", rdata_a[63:32], 32'hDEADBEEF);
        chk("wr_r5_b_p1", rdata_b[63:32], 32'hDEADBEEF);

        // 3. Zero register ignores write and reserve, even via bypass.
        regwrite = 1'b1; writeRegister = 5'd0; writeData = 32'hFFFFFFFF;
        reserve = 1'b1; reserveRegister = 5'd0;
        rd(5'd0, 5'd5);
        chk("r0_bypass", rdata_a[31:0], 32'h0);
        step();
        regwrite = 1'b0; reserve = 1'b0;
        rd(5'd0, 5'd0);
        chk("r0_data", rdata_a[31:0], 32'h0);
        chk("r0_busy", {30'd0, rbusy_a}, 32'd0);

        // 4. Bypass vs. no bypass on r7 (cleared to 0).
        regwrite = 1'b1; writeRegister = 5'd7; writeData = 32'h1234;
        rd(5'd7, 5'd5);
        chk("byp_a_same", rdata_a[31:0], 32'h1234);
        chk("byp_b_old", rdata_b[31:0], 32'h0);
        chk("byp_a_other", rdata_a[63:32], 32'hDEADBEEF);
        step();
        regwrite = 1'b0;
        rd(5'd7, 5'd7);
        chk("byp_b_next", rdata_b[31:0], 32'h1234);

        // 5. Scoreboard on r3.
        reserve = 1'b1; reserveRegister = 5'd3;
        step();
        reserve = 1'b0;
        rd(5'd3, 5'd3);
        chk("sb_reserved", {30'd0, rbusy_a}, 32'd3);
        regwrite = 1'b1; writeRegister = 5'd3; writeData = 32'hAA;
        rd(5'd3, 5'd4);
        chk("sb_byp_busy_a", {31'd0, rbusy_a[0]}, 32'd0);
        chk("sb_old_busy_b", {31'd0, rbusy_b[0]}, 32'd1);
        step();
        regwrite = 1'b0;
        rd(5'd3, 5'd3);
        chk("sb_released", {30'd0, rbusy_a}, 32'd0);
        chk("sb_data", rdata_b[31:0], 32'hAA);
        regwrite = 1'b1; writeRegister = 5'd3; writeData = 32'h55;
        reserve = 1'b1; reserveRegister = 5'd3;
        step();
        regwrite = 1'b0; reserve = 1'b0;
        rd(5'd3, 5'd3);
        chk("sb_both_data", rdata_a[31:0], 32'h55);
        chk("sb_both_busy", {30'd0, rbusy_b}, 32'd3);

        // 6. Mid-run reset with r3 and r9 busy; ops during clear must be ignored.
        reserve = 1'b1; reserveRegister = 5'd9;
        step();
        reserve = 1'b0;
        rd(5'd9, 5'd3);
        chk("pre_rst_busy", {30'd0, rbusy_a}, 32'd3);
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", {31'd0, ready_a}, 32'd0);
        step();
        reset = 1'b0;
        regwrite = 1'b1; writeRegister = 5'd2; writeData = 32'hCAFE;
        reserve = 1'b1; reserveRegister = 5'd2;
        rd(5'd5, 5'd2);
        chk("clr2_rdata", rdata_a[31:0], 32'h0);
        chk("clr2_rbusy", {30'd0, rbusy_b}, 32'd0);
        clear_wait("clr2");
        regwrite = 1'b0; reserve = 1'b0;
        rd(5'd2, 5'd5);
        chk("clr2_r2_data", rdata_a[31:0], 32'h0);
        chk("clr2_r5_data", rdata_a[63:32], 32'h0);
        chk("clr2_r2_busy", {31'd0, rbusy_a[0]}, 32'd0);
        rd(5'd3, 5'd9);
        chk("clr2_r3r9_busy", {30'd0, rbusy_a}, 32'd0);
        chk("clr2_r3_data", rdata_b[31:0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
